result_demux_unit: RTL and testbench

- Write-back end of the Montgomery-multiplier datapath: takes each finished product from the multiplier and steers it back into the operand registers that feed the operand-select mux.
- A one-entry holding register and a two-state FSM commit one result every two cycles.
- Per-operand valid flags, a direct preload path and a saturating commit counter are exported to the RSA sequencer.

---
 rtl/result_demux_unit_pkg.sv | 38 +++
 rtl/result_demux_unit.sv | 130 +++++++++++++
 tb/tb_result_demux_unit.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/result_demux_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : result_demux_unit_pkg                                  |
// | Description : Shared encodings for the Montgomery write-back demux:  |
// |               destination codes, FSM states, commit-count ceiling.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package result_demux_unit_pkg;

  // Destination select carried alongside each multiplier result
  typedef enum logic [1:0] {
    DEST_A    = 2'b00,
    DEST_B    = 2'b01,
    DEST_AB   = 2'b10,
    DEST_NONE = 2'b11
  } dest_e;

  // Write-back FSM: accept a result in IDLE, commit it in WRITE
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  // Ceiling of the saturating commit counter
  localparam logic [7:0] WB_CNT_MAX = 8'd255;

  // True when a destination code updates operand A
  function automatic logic dest_hits_a(input dest_e d);
    return (d == DEST_A) || (d == DEST_AB);
  endfunction

  // True when a destination code updates operand B
  function automatic logic dest_hits_b(input dest_e d);
    return (d == DEST_B) || (d == DEST_AB);
  endfunction

endpackage : result_demux_unit_pkg
`default_nettype wire

// File: rtl/result_demux_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : result_demux_unit                                      |
// | Description : Write-back end of the Montgomery multiplier. Holds one |
// |               finished product and commits it into operand register  |
// |               A, B, both or nowhere, one result every two cycles.    |
// |               Also provides a direct preload path, per-operand valid |
// |               flags and a saturating commit counter.                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module result_demux_unit
  import result_demux_unit_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] res_i,
  input  logic [1:0]       res_dest_i,
  input  logic             res_valid_i,
  output logic             res_ready_o,
  input  logic             ld_en_i,
  input  logic [WIDTH-1:0] ld_a_i,
  input  logic [WIDTH-1:0] ld_b_i,
  input  logic             clr_a_i,
  input  logic             clr_b_i,
  output logic [WIDTH-1:0] a_out_o,
  output logic [WIDTH-1:0] b_out_o,
  output logic             a_valid_o,
  output logic             b_valid_o,
  output logic             done_o,
  output logic             busy_o,
  output logic [7:0]       wb_count_o
);

  state_e           state_q;
  logic [WIDTH-1:0] hold_res_q;
  dest_e            hold_dest_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             a_valid_q;
  logic             b_valid_q;
  logic             done_q;
  logic             busy_q;
  logic [7:0]       wb_count_q;

  logic             commit_d;
  logic             load_d;
  logic             accept_d;
  logic             wr_a_d;
  logic             wr_b_d;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;
  logic             a_valid_d;
  logic             b_valid_d;
  logic [7:0]       wb_count_d;

  // Ready depends only on state and preload request; preload wins in IDLE
  assign res_ready_o = (state_q == IDLE) && !ld_en_i;

  // Next values for operand registers, flags and counter (set beats clear)
  always_comb begin
    commit_d   = (state_q == WRITE);
    load_d     = (state_q == IDLE) && ld_en_i;
    accept_d   = res_valid_i && res_ready_o;
    wr_a_d     = load_d || (commit_d && dest_hits_a(hold_dest_q));
    wr_b_d     = load_d || (commit_d && dest_hits_b(hold_dest_q));
    a_d        = load_d ? ld_a_i : hold_res_q;
    b_d        = load_d ? ld_b_i : hold_res_q;
    a_valid_d  = wr_a_d ? 1'b1 : (clr_a_i ? 1'b0 : a_valid_q);
    b_valid_d  = wr_b_d ? 1'b1 : (clr_b_i ? 1'b0 : b_valid_q);
    wb_count_d = wb_count_q;
    if (commit_d && (hold_dest_q != DEST_NONE) && (wb_count_q != WB_CNT_MAX)) begin
      wb_count_d = wb_count_q + 8'd1;
    end
  end

  // FSM with registered outputs; reset drops any held result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_res_q  <= '0;
      hold_dest_q <= DEST_NONE;
      a_q         <= '0;
      b_q         <= '0;
      a_valid_q   <= 1'b0;
      b_valid_q   <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      wb_count_q  <= 8'd0;
    end else begin
      a_valid_q  <= a_valid_d;
      b_valid_q  <= b_valid_d;
      wb_count_q <= wb_count_d;
      if (wr_a_d) a_q <= a_d;
      if (wr_b_d) b_q <= b_d;
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (accept_d) begin
            hold_res_q  <= res_i;
            hold_dest_q <= dest_e'(res_dest_i);
            busy_q      <= 1'b1;
            state_q     <= WRITE;
          end
        end
        WRITE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign a_out_o    = a_q;
  assign b_out_o    = b_q;
  assign a_valid_o  = a_valid_q;
  assign b_valid_o  = b_valid_q;
  assign done_o     = done_q;
  assign busy_o     = busy_q;
  assign wb_count_o = wb_count_q;

endmodule : result_demux_unit
`default_nettype wire

// File: tb/tb_result_demux_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_result_demux_unit                                   |
// | Description : Scoreboard bench for result_demux_unit: directed cases |
// |               followed by random traffic against a reference model.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_result_demux_unit;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] res_i;
  logic [1:0]   res_dest_i;
  logic         res_valid_i;
  logic         res_ready_o;
  logic         ld_en_i;
  logic [W-1:0] ld_a_i;
  logic [W-1:0] ld_b_i;
  logic         clr_a_i;
  logic         clr_b_i;
  logic [W-1:0] a_out_o;
  logic [W-1:0] b_out_o;
  logic         a_valid_o;
  logic         b_valid_o;
  logic         done_o;
  logic         busy_o;
  logic [7:0]   wb_count_o;

  always #5 clk = ~clk;

  result_demux_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .res_i       (res_i),
    .res_dest_i  (res_dest_i),
    .res_valid_i (res_valid_i),
    .res_ready_o (res_ready_o),
    .ld_en_i     (ld_en_i),
    .ld_a_i      (ld_a_i),
    .ld_b_i      (ld_b_i),
    .clr_a_i     (clr_a_i),
    .clr_b_i     (clr_b_i),
    .a_out_o     (a_out_o),
    .b_out_o     (b_out_o),
    .a_valid_o   (a_valid_o),
    .b_valid_o   (b_valid_o),
    .done_o      (done_o),
    .busy_o      (busy_o),
    .wb_count_o  (wb_count_o)
  );

  // Expected architectural state after a commit
  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         av;
    logic         bv;
    logic [7:0]   cnt;
  } snap_t;

  snap_t exp_q[$];

  // Reference model: operand values, flags, a pending result and a count
  logic [W-1:0] m_a, m_b, m_hres;
  logic [1:0]   m_hdest;
  bit           m_av, m_bv, m_pend, m_done;
  int           m_cnt;

  int n_vec = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_a = '0; m_b = '0; m_hres = '0; m_hdest = 2'b11;
    m_av = 0; m_bv = 0; m_pend = 0; m_done = 0; m_cnt = 0;
  endtask

  // Apply one cycle of inputs and advance the model to the post-edge state
  task automatic step(input bit r, input bit v, input logic [W-1:0] rs, input logic [1:0] d,
                      input bit ld, input logic [W-1:0] la, input logic [W-1:0] lb,
                      input bit ca, input bit cb);
    bit exp_ready;
    snap_t s;
    @(negedge clk);
    rst = r; res_valid_i = v; res_i = rs; res_dest_i = d;
    ld_en_i = ld; ld_a_i = la; ld_b_i = lb; clr_a_i = ca; clr_b_i = cb;
    #1;
    exp_ready = !m_pend && !ld;
    if (mon_en) chk("res_ready", {31'd0, res_ready_o}, {31'd0, exp_ready});
    m_done = 0;
    if (r) begin
      model_reset();
    end else if (m_pend) begin
      if (ca) m_av = 0;
      if (cb) m_bv = 0;
      if (m_hdest == 2'b00 || m_hdest == 2'b10) begin m_a = m_hres; m_av = 1; end
      if (m_hdest == 2'b01 || m_hdest == 2'b10) begin m_b = m_hres; m_bv = 1; end
      if (m_hdest != 2'b11 && m_cnt < 255) m_cnt = m_cnt + 1;
      m_done = 1;
      m_pend = 0;
      s.a = m_a; s.b = m_b; s.av = m_av; s.bv = m_bv; s.cnt = 8'(m_cnt);
      exp_q.push_back(s);
    end else begin
      if (ca) m_av = 0;
      if (cb) m_bv = 0;
      if (ld) begin
        m_a = la; m_b = lb; m_av = 1; m_bv = 1;
      end else if (v) begin
        m_pend = 1; m_hres = rs; m_hdest = d;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 2'b00, 0, '0, '0, 0, 0);
  endtask

  // Monitor: sample after each rising edge, pop a scoreboard entry per done
  initial begin : g_monitor
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        chk("busy", {31'd0, busy_o}, {31'd0, m_pend});
        chk("done", {31'd0, done_o}, {31'd0, m_done});
        if (done_o === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL commit_unexpected: got done=1 expected no pending commit at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            chk("commit_a",   {28'd0, a_out_o},   {28'd0, e.a});
            chk("commit_b",   {28'd0, b_out_o},   {28'd0, e.b});
            chk("commit_av",  {31'd0, a_valid_o}, {31'd0, e.av});
            chk("commit_bv",  {31'd0, b_valid_o}, {31'd0, e.bv});
            chk("commit_cnt", {24'd0, wb_count_o}, {24'd0, e.cnt});
          end
        end
        chk("a_out",    {28'd0, a_out_o},    {28'd0, m_a});
        chk("b_out",    {28'd0, b_out_o},    {28'd0, m_b});
        chk("a_valid",  {31'd0, a_valid_o},  {31'd0, m_av});
        chk("b_valid",  {31'd0, b_valid_o},  {31'd0, m_bv});
        chk("wb_count", {24'd0, wb_count_o}, m_cnt);
      end
    end
  end

  initial begin : g_stimulus
    rst = 1; res_i = '0; res_dest_i = '0; res_valid_i = 0; ld_en_i = 0;
    ld_a_i = '0; ld_b_i = '0; clr_a_i = 0; clr_b_i = 0;
    model_reset();

    // Reset, then idle with all outputs at reset values
    step(1, 0, '0, 2'b00, 0, '0, '0, 0, 0);
    mon_en = 1'b1;
    step(1, 0, '0, 2'b00, 0, '0, '0, 0, 0);
    idle(2);
    chk("reset_a", {28'd0, a_out_o}, 32'd0);
    chk("reset_cnt", {24'd0, wb_count_o}, 32'd0);
    chk("reset_ready", {31'd0, res_ready_o}, 32'd1);

    // Single result to A
    step(0, 1, 4'hA, 2'b00, 0, '0, '0, 0, 0);
    idle(3);
    chk("dest_a_value", {28'd0, a_out_o}, 32'hA);
    chk("dest_a_cnt", {24'd0, wb_count_o}, 32'd1);

    // Back-to-back offers: second one waits out the WRITE cycle
    step(0, 1, 4'h3, 2'b01, 0, '0, '0, 0, 0);
    step(0, 1, 4'h5, 2'b10, 0, '0, '0, 0, 0);
    step(0, 1, 4'h5, 2'b10, 0, '0, '0, 0, 0);
    idle(3);
    chk("b2b_a", {28'd0, a_out_o}, 32'h5);
    chk("b2b_b", {28'd0, b_out_o}, 32'h5);
    chk("b2b_cnt", {24'd0, wb_count_o}, 32'd3);

    // Preload collides with an offered result; result taken next cycle
    step(0, 1, 4'h2, 2'b01, 1, 4'h7, 4'h9, 0, 0);
    step(0, 1, 4'h2, 2'b01, 0, '0, '0, 0, 0);
    idle(3);
    chk("preload_a", {28'd0, a_out_o}, 32'h7);

    // Discard destination
    step(0, 1, 4'hF, 2'b11, 0, '0, '0, 0, 0);
    idle(3);

    // Clear of A coinciding with a commit to A: set wins
    step(0, 0, '0, 2'b00, 0, '0, '0, 1, 1);
    step(0, 1, 4'h6, 2'b00, 0, '0, '0, 0, 0);
    step(0, 0, '0, 2'b00, 0, '0, '0, 1, 0);
    idle(2);
    chk("clr_vs_set_av", {31'd0, a_valid_o}, 32'd1);

    // Reset while a result is held
    step(0, 1, 4'hC, 2'b10, 0, '0, '0, 0, 0);
    step(1, 0, '0, 2'b00, 0, '0, '0, 0, 0);
    idle(3);
    chk("rst_write_b", {28'd0, b_out_o}, 32'd0);

    // Saturation of the commit counter
    for (int i = 0; i < 260; i++) begin
      step(0, 1, 4'($urandom), 2'($urandom_range(0, 2)), 0, '0, '0, 0, 0);
      step(0, 0, '0, 2'b00, 0, '0, '0, 0, 0);
    end
    idle(3);
    chk("sat_cnt", {24'd0, wb_count_o}, 32'd255);

    // Random traffic with occasional reset
    step(1, 0, '0, 2'b00, 0, '0, '0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 127) == 0),
           1'($urandom_range(0, 3) != 0),
           4'($urandom), 2'($urandom),
           ($urandom_range(0, 5) == 0),
           4'($urandom), 4'($urandom),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 4) == 0));
    end
    idle(4);

    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending entries expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_result_demux_unit
`default_nettype wire
